// File: rtl/draw_starfield_layers.sv
// Multi-layer parallax LFSR starfield, lowest-priority background drawer.
// Optional STARS_TWINKLE_EN: halve brightness when the star's LFSR source is odd.
module draw_starfield_layers #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int LAYERS = 3,
  parameter int LFSR_BITS = 10,
  parameter logic [LFSR_BITS-1:0] LFSR_POLY = 10'h240,
  parameter logic [LFSR_BITS-1:0] SEED = 10'h001,
  parameter int MIN_GAP = 0
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      pxl_en,
  input  logic [$clog2(WIDTH)-1:0]  pxl_x,
  input  logic [$clog2(HEIGHT)-1:0] pxl_y,
  input  logic                      scroll_en,
  output logic [3:0]                Red,
  output logic [3:0]                Green,
  output logic [3:0]                Blue,
  output logic                      Draw,
  output logic [1:0]                layer_id
);

  localparam int CW = LFSR_BITS + 3;

  typedef logic [LFSR_BITS-1:0] lfsr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic lfsr_t step(input lfsr_t v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  function automatic cnt_t gap(input lfsr_t v, input int l);
    cnt_t w;
    w = cnt_t'(v);
    return (w << l) + cnt_t'(MIN_GAP);
  endfunction

  function automatic lfsr_t seed_of(input int l);
    lfsr_t s;
    s = SEED ^ lfsr_t'(l << 1);
    return (s == '0) ? lfsr_t'(1) : s;
  endfunction

  function automatic logic adv_of(
    input logic [LAYERS-1:0] fc,
    input int l
  );
    logic [LAYERS-1:0] m;
    m = LAYERS'((1 << l) - 1);
    return (fc & m) == '0;
  endfunction

  lfsr_t lfsr  [LAYERS];
  cnt_t  cnt   [LAYERS];
  lfsr_t fseed [LAYERS];

  logic [LAYERS-1:0] frame_cnt;
  logic [LAYERS-1:0] hit;
  logic              armed;
  logic              frame_start;
  logic [1:0]        win;
  logic [3:0]        base;
  logic [3:0]        col;
  logic [3:0]        colour;

  // Descending scan so the nearest (lowest index) hitting layer wins.
  always_comb begin
    frame_start = pxl_en && (pxl_x == '0) && (pxl_y == '0);
    hit  = '0;
    win  = '0;
    base = '0;
    col  = '0;
    for (int l = LAYERS - 1; l >= 0; l--) begin
      hit[l] = pxl_en && !frame_start && (cnt[l] == '0);
      if (hit[l]) begin
        win  = 2'(l);
        base = 4'(15 - 4 * l);
`ifdef STARS_TWINKLE_EN
        // MSB of a stepped Galois LFSR equals bit 0 of its predecessor.
        col  = lfsr[l][LFSR_BITS-1] ? (base >> 1) : base;
`else
        col  = base;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int l = 0; l < LAYERS; l++) begin
        lfsr[l]  <= seed_of(l);
        cnt[l]   <= '0;
        fseed[l] <= seed_of(l);
      end
      frame_cnt <= '0;
      armed     <= 1'b0;
    end else if (frame_start) begin
      armed <= 1'b1;
      if (scroll_en)
        frame_cnt <= frame_cnt + 1'b1;
      for (int l = 0; l < LAYERS; l++) begin
        lfsr[l] <= step(fseed[l]);
        cnt[l]  <= gap(fseed[l], l);
        if (scroll_en && adv_of(frame_cnt, l))
          fseed[l] <= step(fseed[l]);
      end
    end else if (pxl_en) begin
      for (int l = 0; l < LAYERS; l++) begin
        if (hit[l]) begin
          cnt[l]  <= gap(lfsr[l], l);
          lfsr[l] <= step(lfsr[l]);
        end else begin
          cnt[l]  <= cnt[l] - 1'b1;
        end
      end
    end
  end

  // Hits before the first frame start after reset advance state silently.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      Draw     <= 1'b0;
      layer_id <= '0;
      colour   <= '0;
    end else if (!pxl_en) begin
      Draw     <= 1'b0;
      layer_id <= '0;
    end else if (armed && (|hit)) begin
      Draw     <= 1'b1;
      layer_id <= win;
      colour   <= col;
    end else begin
      Draw     <= 1'b0;
      layer_id <= '0;
      colour   <= '0;
    end
  end

  assign Red   = colour;
  assign Green = colour;
  assign Blue  = colour;

endmodule

// File: tb/tb_draw_starfield_layers.sv
// Bench for draw_starfield_layers: random pixel stream vs star-position model.
// Expected star pixels come from summed gaps per layer, not countdowns.
module tb_draw_starfield_layers;

  localparam int LAYERS  = 3;
  localparam int MIN_GAP = 0;
  localparam int NMAP    = 4096;

`ifdef STARS_TWINKLE_EN
  localparam logic [14:0] D2   = {1'b1, 2'd0, 12'h777};
  localparam logic [14:0] D7   = {1'b1, 2'd1, 12'h555};
  localparam logic [14:0] D21  = {1'b1, 2'd2, 12'h333};
  localparam logic [14:0] D579 = {1'b1, 2'd0, 12'hFFF};
`else
  localparam logic [14:0] D2   = {1'b1, 2'd0, 12'hFFF};
  localparam logic [14:0] D7   = {1'b1, 2'd1, 12'hBBB};
  localparam logic [14:0] D21  = {1'b1, 2'd2, 12'h777};
  localparam logic [14:0] D579 = {1'b1, 2'd0, 12'hFFF};
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic       pxl_en;
  logic [9:0] pxl_x;
  logic [8:0] pxl_y;
  logic       scroll_en;
  logic [3:0] Red, Green, Blue;
  logic       Draw;
  logic [1:0] layer_id;

  int total = 0;
  int bad   = 0;

  draw_starfield_layers #(
    .WIDTH(640), .HEIGHT(480), .LAYERS(LAYERS), .LFSR_BITS(10),
    .LFSR_POLY(10'h240), .SEED(10'h001), .MIN_GAP(MIN_GAP)
  ) dut (
    .clk(clk), .resetN(resetN), .pxl_en(pxl_en),
    .pxl_x(pxl_x), .pxl_y(pxl_y), .scroll_en(scroll_en),
    .Red(Red), .Green(Green), .Blue(Blue),
    .Draw(Draw), .layer_id(layer_id)
  );

  always #5 clk = ~clk;

  logic [9:0]        m_fseed [LAYERS];
  int                m_s;
  bit                m_armed;
  int                m_k;
  logic [3:0]        m_col;
  bit [LAYERS-1:0]   m_map [NMAP];
  bit [LAYERS-1:0]   m_tw  [NMAP];
  logic [14:0]       exp_v;

  function automatic logic [9:0] f_step(input logic [9:0] v);
    return v[0] ? ((v >> 1) ^ 10'h240) : (v >> 1);
  endfunction

  function automatic logic [9:0] f_seed(input int l);
    logic [9:0] s;
    s = 10'h001 ^ 10'(l * 2);
    return (s == 10'd0) ? 10'd1 : s;
  endfunction

  function automatic logic [14:0] obs();
    return {Draw, layer_id, Red, Green, Blue};
  endfunction

  task automatic m_reset();
    for (int l = 0; l < LAYERS; l++) m_fseed[l] = f_seed(l);
    m_s = 0;
    m_armed = 1'b0;
    m_k = 0;
    m_col = 4'd0;
  endtask

  // Star j of a layer lands gap(v_j)+1 enabled pixels after star j-1.
  task automatic m_frame(input bit scroll);
    logic [9:0] v;
    int p;
    for (int k = 0; k < NMAP; k++) begin
      m_map[k] = '0;
      m_tw[k]  = '0;
    end
    for (int l = 0; l < LAYERS; l++) begin
      v = m_fseed[l];
      p = 0;
      for (int j = 0; j < NMAP; j++) begin
        p = p + int'(v) * (1 << l) + MIN_GAP + 1;
        if (p >= NMAP) break;
        m_map[p][l] = 1'b1;
        m_tw[p][l]  = v[0];
        v = f_step(v);
      end
    end
    if (scroll) begin
      for (int l = 0; l < LAYERS; l++)
        if (m_s % (1 << l) == 0) m_fseed[l] = f_step(m_fseed[l]);
      m_s++;
    end
    m_armed = 1'b1;
    m_k = 0;
  endtask

  task automatic pix(input bit en, input bit org, input bit scroll);
    int w;
    logic [3:0] c;
    pxl_en = en;
    if (org) begin
      pxl_x = 10'd0;
      pxl_y = 9'd0;
    end else begin
      pxl_x = 10'($urandom_range(0, 639));
      pxl_y = 9'($urandom_range(0, 479));
      if (pxl_x == 10'd0 && pxl_y == 9'd0) pxl_x = 10'd1;
    end
    scroll_en = (en && org) ? scroll : 1'($urandom_range(0, 1));
    if (!en) begin
      exp_v = {1'b0, 2'b0, m_col, m_col, m_col};
    end else if (org) begin
      m_frame(scroll);
      m_col = 4'd0;
      exp_v = '0;
    end else begin
      m_k++;
      if (m_armed && m_k < NMAP && m_map[m_k] != '0) begin
        w = 0;
        while (!m_map[m_k][w]) w++;
        c = 4'(15 - 4 * w);
`ifdef STARS_TWINKLE_EN
        if (m_tw[m_k][w]) c = c >> 1;
`endif
        m_col = c;
        exp_v = {1'b1, 2'(w), c, c, c};
      end else begin
        m_col = 4'd0;
        exp_v = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    pxl_en = 1'b0;
    pxl_x = '0;
    pxl_y = '0;
    scroll_en = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs() !== 15'h0) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs(), 15'h0);
    end
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL pre_frame i=%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_first_frame();
    pix(1'b1, 1'b1, 1'b0);
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL frame_start got=%h want=%h", obs(), exp_v);
    end
    for (int k = 1; k <= 1200; k++) begin
      pix(1'b1, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL first_frame k=%0d got=%h want=%h", k, obs(), exp_v);
      end
      if (k == 2 || k == 7 || k == 21 || k == 579) begin
        total++;
        if (obs() !== (k == 2 ? D2 : k == 7 ? D7 : k == 21 ? D21 : D579)) begin
          bad++;
          $display("FAIL first_star_fixed k=%0d got=%h", k, obs());
        end
      end
    end
  endtask

  task automatic test_stall();
    pix(1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL stall_pre got=%h want=%h", obs(), exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      pix(1'b0, i == 2, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL stall_hold i=%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
    pix(1'b1, 1'b0, 1'b0);
    total++;
    if (obs() !== D2) begin
      bad++;
      $display("FAIL stall_star got=%h want=%h", obs(), D2);
    end
    for (int i = 0; i < 3; i++) begin
      pix(1'b0, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL stall_colour_hold i=%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
    for (int i = 0; i < 2000; i++) begin
      pix($urandom_range(0, 3) != 0, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL stall_rand i=%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_scroll();
    int n;
    for (int f = 0; f < 6; f++) begin
      pix(1'b1, 1'b1, f < 4);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL scroll_start f=%0d got=%h want=%h", f, obs(), exp_v);
      end
      n = $urandom_range(800, 2000);
      for (int i = 0; i < n; i++) begin
        pix($urandom_range(0, 3) != 0, 1'b0, 1'b0);
        total++;
        if (obs() !== exp_v) begin
          bad++;
          $display("FAIL scroll f=%0d i=%0d got=%h want=%h", f, i, obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    pix(1'b1, 1'b1, 1'b1);
    pix(1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0);
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL pre_reset_star got=%h want=%h", obs(), exp_v);
    end
    #2;
    resetN = 1'b0;
    #1;
    total++;
    if (obs() !== 15'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", obs(), 15'h0);
    end
    m_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix(1'b1, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL post_reset_idle i=%0d got=%h want=%h", i, obs(), exp_v);
      end
    end
    pix(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 1200; k++) begin
      pix(1'b1, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%h want=%h", k, obs(), exp_v);
      end
      if (k == 2) begin
        total++;
        if (obs() !== D2) begin
          bad++;
          $display("FAIL post_reset_first_star got=%h want=%h", obs(), D2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 5; f++) begin
      pix(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      pix(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL b2b_start f=%0d got=%h want=%h", f, obs(), exp_v);
      end
      n = $urandom_range(600, 1800);
      for (int i = 0; i < n; i++) begin
        pix($urandom_range(0, 4) != 0, 1'b0, 1'b0);
        total++;
        if (obs() !== exp_v) begin
          bad++;
          $display("FAIL b2b f=%0d i=%0d got=%h want=%h", f, i, obs(), exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stall();
    test_scroll();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_starfield_layers.md
Name: draw_starfield_layers

Overview:
Multi-layer parallax starfield background generator for the VGA arcade pipeline. Successor to the single-layer star drawer. Generalised to LAYERS independent LFSR star streams, each with its own density and brightness. Adds a pixel-enable qualifier and per-frame drift so far layers move slower than near ones. Sits ahead of the object mux as the lowest-priority drawer.

Parameters:
WIDTH, 640, active pixel columns; pxl_x width = $clog2(WIDTH)
HEIGHT, 480, active pixel rows; pxl_y width = $clog2(HEIGHT)
LAYERS, 3, number of star layers, legal 1..4; layer 0 is nearest and brightest
LFSR_BITS, 10, LFSR and base gap width
LFSR_POLY, 10'h240, Galois tap mask (x^10+x^7+1, maximal length)
SEED, 10'h001, base seed
MIN_GAP, 0, constant added to every inter-star gap

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous active-low reset
pxl_en  in  1  pxl_x/pxl_y valid this cycle; state advances only when high
pxl_x  in  $clog2(WIDTH)  current pixel column
pxl_y  in  $clog2(HEIGHT)  current pixel row
scroll_en  in  1  enables drift; sampled at frame start
Red  out  4  star colour
Green  out  4  star colour (equal to Red)
Blue  out  4  star colour (equal to Red)
Draw  out  1  star pixel this cycle
layer_id  out  2  index of the winning layer when Draw=1, else 0

Behaviour:
- Reset: clk and resetN are the only clock and reset. resetN is asynchronous and active-low. Red/Green/Blue/Draw/layer_id=0; frame_cnt=0; cnt_L=0; lfsr_L=seed_L; frame_seed_L=seed_L.
- Layer seeds: seed_L = SEED ^ (L<<1); any zero result is replaced by 1.
- step(v) = v[0] ? (v>>1)^LFSR_POLY : v>>1.
- gap_L(v) = (v<<L)+MIN_GAP, width LFSR_BITS+3. Far layers are sparser.
- Frame start means pxl_en && pxl_x==0 && pxl_y==0. For each L:
  - lfsr_L <= step(frame_seed_L); cnt_L <= gap_L(frame_seed_L); no hit.
  - Overrides any hit in the same cycle.
- Other pixel with pxl_en=1, per layer L:
  - If cnt_L==0: hit_L=1, cnt_L <= gap_L(lfsr_L), lfsr_L <= step(lfsr_L).
  - Else: cnt_L <= cnt_L-1.
- pxl_en=0: all layer state holds. Next-cycle Draw=0, layer_id=0, colours keep their last value.
- Output stage, registered, latency 1 clk after the qualifying pixel:
  - Draw = OR of hit_L.
  - Winner is the lowest L with hit_L=1.
  - layer_id = winner.
  - Colour = base_L = 15-4L (F,B,7,3).
  - Non-Draw cycles: colours = 0.
- Drift, evaluated at frame start:
  - If scroll_en: frame_cnt++ (wraps at 2^LAYERS).
  - frame_seed_L <= step(frame_seed_L) when frame_cnt[L-1:0]==0. Layer 0 advances every frame; layer L advances every 2^L frames.
  - The new frame_seed_L is used from the next frame start.
  - scroll_en=0: frame_cnt and frame_seed hold; the pattern is static.
- Reset mid-frame: everything returns to reset values. Draw stays 0 until counters expire after the next frame start. Pixels before that frame start still advance from the reset state.
- Unused layer_id bits are 0 when LAYERS<3.

Optional Feature:
Macro: STARS_TWINKLE_EN.
- Defined: a winning star's colour is base_L when the pre-step lfsr_L[0]==0, and base_L>>1 when 1. The value is registered with Draw.
- Undefined: colour is always base_L; no extra logic.

Test Plan:
1. LAYERS=1, SEED=1, MIN_GAP=0, pxl_en=1 constant, frame start at cycle 0 → cnt=1. Draw=1, colour F, one clk after pixel 2. Next star one clk after pixel 579 (gap 0x240=576).
2. Same as 1 with pxl_en deasserted for 5 cycles after pixel 1 → star pixel is unchanged (the 2nd enabled pixel after frame start). Draw stays 0 during the stall.
3. LAYERS=3, force layers 0 and 2 to hit the same pixel via seeds → Draw=1, layer_id=0, colour F. Repeat with only layers 1 and 2 hitting → layer_id=1, colour B.
4. scroll_en=1 for 4 frames, LAYERS=3 → frame_seed_0 steps 4 times, frame_seed_1 twice, frame_seed_2 once. scroll_en=0 → identical star positions in consecutive frames.
5. resetN pulsed low mid-frame → all outputs 0 within the same cycle (async). After the next frame start, the star sequence equals the post-reset frame-0 sequence.
6. STARS_TWINKLE_EN defined, LAYERS=1, SEED=1 → first star (pre-step lfsr=1) colour 7; the second star (lfsr=0x240, bit0=0) colour F.
